// File: rtl/key_event_queue.sv
// Key-press event queue: serialises per-key press pulses, lowest index first,
// into a small FIFO of binary key codes drained by a valid/ready handshake.
module key_event_queue #(
  parameter int WIDTH  = 5,
  parameter int CODE_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           key_pulse,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [CODE_W-1:0]          evt_code,
  output logic [$clog2(DEPTH):0]     evt_count,
  input  logic                       ovf_clr,
  output logic                       ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]  pend_q, pend_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] mem_q [DEPTH];

  logic              full;
  logic              found;
  logic [CODE_W-1:0] grant_idx;
  logic [WIDTH-1:0]  grant;
  logic              push;
  logic              pop;

  assign full = (count_q == CNT_W'(DEPTH));

  // Priority pick of the lowest pending key; a full FIFO blocks every grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i] && !found) begin
        found     = 1'b1;
        grant_idx = CODE_W'(i);
        if (!full) begin
          grant[i] = 1'b1;
        end
      end
    end
  end

  assign push = found && !full;
  assign pop  = (count_q != '0) && evt_ready;

  always_comb begin
    pend_d = (pend_q & ~grant) | key_pulse;

    // A set in the same cycle as a clear must win.
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (|(key_pulse & pend_q & ~grant)) begin
      ovf_d = 1'b1;
    end

    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push) begin
        mem_q[wptr_q] <= grant_idx;
      end
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_code  = mem_q[rptr_q];
  assign evt_count = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: expected codes are queued when presses
// are driven and compared whenever the DUT hands over an event.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_pulse;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
  logic       ovf_clr;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int sb[$];

  key_event_queue #(.WIDTH(5), .CODE_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_pulse (key_pulse),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: compare any handed-over event at the falling edge, then
  // advance past the rising edge and drop the one-cycle inputs.
  task automatic step();
    int e;
    @(negedge clk);
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_evt", {31'd0, evt_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("evt_code", {29'd0, evt_code}, e);
      end
    end
    @(posedge clk);
    #1;
    key_pulse = '0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    int seq[10] = '{3, 0, 4, 1, 2, 2, 0, 3, 1, 4};
    int guard;

    // Reset with all keys pulsing
    rst_n = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0; key_pulse = 5'b11111;
    step();
    key_pulse = 5'b11111;
    step();
    rst_n = 1'b1;
    chk("rst_count", {29'd0, evt_count}, 0);
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_ovf",   {31'd0, ovf}, 0);
    chk("rst_code",  {29'd0, evt_code}, 0);
    step(); step(); step();
    chk("rst_no_evt", {31'd0, evt_valid}, 0);

    // Single press, latency two cycles
    evt_ready = 1'b1;
    key_pulse = 5'b00100; sb.push_back(2);
    step();
    chk("single_t1_valid", {31'd0, evt_valid}, 0);
    step();
    chk("single_t2_valid", {31'd0, evt_valid}, 1);
    chk("single_t2_code",  {29'd0, evt_code}, 2);
    chk("single_t2_count", {29'd0, evt_count}, 1);
    step();
    chk("single_t3_count", {29'd0, evt_count}, 0);
    chk("single_t3_valid", {31'd0, evt_valid}, 0);

    // Simultaneous presses serialise in ascending order
    evt_ready = 1'b0;
    key_pulse = 5'b10011; sb.push_back(0); sb.push_back(1); sb.push_back(4);
    step(); step();
    chk("simul_t2_count", {29'd0, evt_count}, 1);
    step(); step();
    chk("simul_t4_count", {29'd0, evt_count}, 3);
    evt_ready = 1'b1;
    step(); step(); step();
    chk("simul_drained", {29'd0, evt_count}, 0);
    chk("simul_ovf", {31'd0, ovf}, 0);

    // Full FIFO holds the pending key, a repeat press overflows
    evt_ready = 1'b0;
    key_pulse = 5'b11111;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    step(); step(); step(); step(); step();
    chk("full_count", {29'd0, evt_count}, 4);
    step();
    chk("full_hold_count", {29'd0, evt_count}, 4);
    chk("full_no_ovf", {31'd0, ovf}, 0);
    key_pulse = 5'b10000;
    step();
    chk("full_ovf", {31'd0, ovf}, 1);
    chk("full_count2", {29'd0, evt_count}, 4);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    sb.push_back(4);
    chk("full_pop_no_push", {29'd0, evt_count}, 3);
    step();
    chk("full_refill", {29'd0, evt_count}, 4);
    evt_ready = 1'b1;
    step(); step(); step(); step();
    chk("full_drained", {29'd0, evt_count}, 0);
    chk("full_ovf_sticky", {31'd0, ovf}, 1);
    evt_ready = 1'b0;
    ovf_clr = 1'b1;
    step();
    chk("ovf_cleared", {31'd0, ovf}, 0);

    // Re-press on the grant cycle re-arms without loss
    key_pulse = 5'b00010; sb.push_back(1);
    step();
    key_pulse = 5'b00010; sb.push_back(1);
    step(); step();
    chk("rearm_count", {29'd0, evt_count}, 2);
    chk("rearm_ovf", {31'd0, ovf}, 0);
    key_pulse = 5'b01100; sb.push_back(2); sb.push_back(3);
    step();
    key_pulse = 5'b01000; ovf_clr = 1'b1;
    step();
    chk("set_beats_clr", {31'd0, ovf}, 1);
    step();
    chk("rearm_count2", {29'd0, evt_count}, 4);
    ovf_clr = 1'b1;
    step();
    chk("ovf_cleared2", {31'd0, ovf}, 0);
    evt_ready = 1'b1;
    step(); step(); step(); step();
    chk("rearm_drained", {29'd0, evt_count}, 0);

    // Ten events through the wrapping pointers, ready toggling
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_pulse = '0;
      key_pulse[seq[i]] = 1'b1;
      sb.push_back(seq[i]);
      evt_ready = ~evt_ready;
      step();
      evt_ready = ~evt_ready;
      step();
    end
    guard = 0;
    while ((evt_count != 3'd0 || sb.size() != 0) && guard < 40) begin
      evt_ready = ~evt_ready;
      step();
      guard++;
    end
    chk("wrap_timeout", guard, (guard < 40) ? guard : 0);
    chk("wrap_drained", {29'd0, evt_count}, 0);
    chk("wrap_sb_empty", sb.size(), 0);

    // Reset with events queued discards them
    evt_ready = 1'b0;
    key_pulse = 5'b00111;
    step(); step(); step(); step();
    chk("pre_rst_count", {29'd0, evt_count}, 3);
    rst_n = 1'b0;
    sb.delete();
    step();
    chk("midrst_valid", {31'd0, evt_valid}, 0);
    chk("midrst_count", {29'd0, evt_count}, 0);
    chk("midrst_code",  {29'd0, evt_code}, 0);
    rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_valid", {31'd0, evt_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
